fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Producer side of the IF/ID interface: generates the PC, runs the instruction-memory request/acknowledge handshake, and drives the instruction/PC pair that the fetch pipeline register samples every clock.
- Supports a downstream stall (hold current output) and a redirect (branch/jump target) with squashing of any in-flight memory response.
- Sits between instruction memory and the fetch latch.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.
- PC_STEP, 4, byte increment per fetched instruction.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- imem_req  output  1  request to instruction memory; level signal held until ack.
- imem_addr  output  32  fetch address; stable while imem_req=1 and no ack.
- imem_ack  input  1  memory response; a transfer completes on a cycle with imem_req=1 and imem_ack=1.
- imem_rdata  input  32  instruction word, valid when imem_ack=1.
- stall  input  1  downstream cannot accept a new instruction; hold outputs.
- redirect  input  1  one-cycle pulse that loads a new PC and flushes the output.
- redirect_pc  input  32  target PC; bits [1:0] ignored (forced to 0).
- instruction  output  32  registered instruction, to the fetch latch.
- PC  output  32  registered PC of `instruction`.
- valid  output  1  `instruction`/`PC` hold a live instruction.

Behaviour:
- Reset:
  - Taken only when rst_n=0 at a clk edge.
  - pc_q=RESET_PC, state=S_IDLE, valid=0, instruction=0, PC=0.
  - Overrides everything, including an in-flight request; any ack arriving during reset is dropped.
- States:
  - S_IDLE: imem_req=0. Unconditionally goes to S_REQ on the next clock; one bubble after reset.
  - S_REQ: imem_req = !(valid && stall), imem_addr=pc_q.
    - Ack with no redirect: instruction<=imem_rdata, PC<=pc_q, valid<=1, pc_q<=pc_q+PC_STEP. Stay in S_REQ.
    - valid=1 and stall=1: no request; outputs hold; go to S_HOLD.
    - No ack and not stalled: valid<=0.
  - S_HOLD: imem_req=0; instruction, PC and valid hold.
    - stall=0: valid<=0, go to S_REQ (one bubble after a stall releases).
  - S_DRAIN: imem_req=1, imem_addr=drain_addr (address of the abandoned request), valid=0.
    - On ack: discard imem_rdata, go to S_REQ at pc_q.
- Redirect (highest priority after reset):
  - pc_q<={redirect_pc[31:2],2'b00}, valid<=0. instruction and PC are not cleared.
  - In S_REQ with imem_req=1 and no ack: go to S_DRAIN so the handshake is never abandoned. drain_addr keeps the old pc_q.
  - In S_REQ with an ack in the same cycle: discard the data, stay in S_REQ.
  - In S_HOLD: overrides stall, go to S_REQ.
  - In S_DRAIN: update pc_q, remain in S_DRAIN until the ack.
- Latency:
  - With ack in the same cycle as req: one instruction per clock, outputs one cycle after the ack edge.
  - First valid output is 2 cycles after reset release at the earliest.
- Arithmetic: pc_q+PC_STEP is modulo 2^32; 32'hFFFF_FFFC wraps to 32'h0000_0000.
- Protocol invariant: once imem_req=1 without ack, imem_req stays 1 and imem_addr stays constant until ack (or reset).

Decomposition:
- Shared pipeline package:
  - fetch FSM state encoding (S_IDLE, S_REQ, S_HOLD, S_DRAIN, 2 bits);
  - RESET_PC default;
  - PC_STEP;
  - a NOP instruction constant 32'h0000_0000.
- One natural sub-module, pc_gen: holds pc_q and implements reset/redirect/increment selection with alignment masking. The FSM and output registers stay in fetch_unit.

Test Plan:
- Reset, imem_ack tied to 1, imem_rdata = addr ^ 32'hA5A5_0000 -> valid first at cycle 2; PC sequence 0,4,8,… one per clock; each instruction = PC ^ 32'hA5A5_0000.
- stall=1 for 3 cycles while valid with PC=8 -> instruction/PC/valid frozen for 3 cycles, imem_req=0; after release one bubble (valid=0), then PC=12.
- Ack delayed 4 cycles, redirect to 32'h0000_0103 on cycle 1 of the wait -> imem_addr holds the old address until ack; that data is discarded (valid stays 0); next request is at 32'h0000_0100.
- redirect in the same cycle as an ack for PC=16 -> data dropped, valid=0 next cycle; following output has PC=redirect_pc.
- RESET_PC=32'hFFFF_FFF8, ack always 1 -> PCs FFFF_FFF8, FFFF_FFFC, 0000_0000.
- rst_n=0 during an outstanding request and during S_HOLD -> next cycle valid=0, PC=0, imem_req=0; fetching restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage.
//   fetch_state_e    : fetch FSM state encoding (2 bits)
//   RESET_PC_DEFAULT : default PC loaded on reset
//   PC_STEP_DEFAULT  : byte increment per fetched instruction
//   NOP_INSN         : value the instruction/PC outputs take on reset
//   align_pc()       : forces a PC to word alignment
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_STEP_DEFAULT  = 32'd4;
  localparam logic [31:0] NOP_INSN         = 32'h0000_0000;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/acknowledge interface.
//   req   : fetch request, a level held until ack
//   addr  : fetch address, stable while req=1 and no ack
//   ack   : memory response; transfer completes when req=1 and ack=1
//   rdata : instruction word, valid when ack=1
// master = fetch unit side, slave = instruction memory side.
interface fetch_unit_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/fetch_unit_pc_gen.sv
// Program counter generator for the fetch stage.
//   clk, rst_n : clock, synchronous active-low reset
//   load       : take target as the new PC (redirect)
//   target     : redirect target; low two bits are masked off
//   advance    : step the PC by PC_STEP (an instruction was accepted)
//   pc_q       : current fetch PC
// Priority: reset, then load, then advance. Increment wraps modulo 2^32.
module fetch_unit_pc_gen
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] target,
  input  logic        advance,
  output logic [31:0] pc_q
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q <= align_pc(RESET_PC);
    end else if (load) begin
      pc_q <= align_pc(target);
    end else if (advance) begin
      pc_q <= pc_q + PC_STEP;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch unit: producer side of the IF/ID interface.
//   clk, rst_n  : clock, synchronous active-low reset
//   imem        : instruction-memory handshake (master modport)
//   stall       : downstream cannot accept; hold the current output
//   redirect    : one-cycle pulse loading redirect_pc and flushing the output
//   redirect_pc : redirect target (low two bits ignored)
//   instruction : registered instruction word for the fetch latch
//   PC          : registered PC of instruction
//   valid       : instruction/PC hold a live instruction
// A request that is outstanding when a redirect arrives is carried to
// completion in S_DRAIN and its data thrown away, so the memory never sees
// a request withdrawn before its acknowledge.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  fetch_unit_if.master        imem,
  input  logic                stall,
  input  logic                redirect,
  input  logic [31:0]         redirect_pc,
  output logic [31:0]         instruction,
  output logic [31:0]         PC,
  output logic                valid
);

  fetch_state_e state;
  fetch_state_e state_next;
  logic [31:0]  pc_q;
  logic [31:0]  drain_addr;
  logic [31:0]  addr_sel;
  logic         req;
  logic         capture;
  logic         hold_out;
  logic         start_drain;

  // PC register lives in its own block
  fetch_unit_pc_gen #(
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_pc_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (redirect),
    .target  (redirect_pc),
    .advance (capture),
    .pc_q    (pc_q)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Output decode: request and address driven toward memory
  always_comb begin
    req      = 1'b0;
    addr_sel = pc_q;
    case (state)
      // A held instruction that downstream refuses blocks new requests.
      // valid=1 only right after an ack, so this never drops a pending req.
      S_REQ:   req = !(valid && stall);
      S_DRAIN: begin
        req      = 1'b1;
        addr_sel = drain_addr;
      end
      default: req = 1'b0;
    endcase
  end

  assign imem.req  = req;
  assign imem.addr = addr_sel;

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  state_next = S_REQ;
      S_REQ: begin
        if (redirect) begin
          state_next = (req && !imem.ack) ? S_DRAIN : S_REQ;
        end else if (valid && stall) begin
          state_next = S_HOLD;
        end
      end
      S_HOLD:  if (redirect || !stall) state_next = S_REQ;
      S_DRAIN: if (imem.ack) state_next = S_REQ;
      default: state_next = S_IDLE;
    endcase
  end

  // Only a non-redirected transfer from S_REQ delivers an instruction;
  // acks in S_DRAIN belong to an abandoned address.
  assign capture     = (state == S_REQ) && req && imem.ack && !redirect;
  assign hold_out    = valid && stall && !redirect;
  assign start_drain = (state == S_REQ) && redirect && req && !imem.ack;

  // Output registers and the address of an abandoned request
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid       <= 1'b0;
      instruction <= NOP_INSN;
      PC          <= NOP_INSN;
      drain_addr  <= '0;
    end else begin
      if (capture) begin
        valid       <= 1'b1;
        instruction <= imem.rdata;
        PC          <= pc_q;
      end else if (!hold_out) begin
        valid <= 1'b0;
      end
      if (start_drain) begin
        drain_addr <= pc_q;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit. A transaction-level model tracks the
// next PC to be delivered and whether the outstanding request belongs to an
// abandoned (redirected) fetch; every cycle it predicts valid/PC/instruction
// and checks the memory handshake rules.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam logic [31:0] K         = 32'hA5A5_0000;
  localparam logic [31:0] DUT_RESET = 32'h0000_0000;
  localparam logic [31:0] WRAP_RESET = 32'hFFFF_FFF8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instruction;
  logic [31:0] pc_out;
  logic        valid;

  fetch_unit_if imem ();

  fetch_unit #(.RESET_PC(DUT_RESET), .PC_STEP(32'd4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem        (imem),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instruction (instruction),
    .PC          (pc_out),
    .valid       (valid)
  );

  // Second instance for the PC wrap-around case, memory always ready
  logic        rst2_n;
  logic        stall2 = 1'b0;
  logic        redirect2 = 1'b0;
  logic [31:0] rpc2 = 32'h0;
  logic [31:0] insn2;
  logic [31:0] pc2;
  logic        valid2;

  fetch_unit_if imem2 ();
  assign imem2.ack   = imem2.req;
  assign imem2.rdata = imem2.addr ^ K;

  fetch_unit #(.RESET_PC(WRAP_RESET), .PC_STEP(32'd4)) dut_wrap (
    .clk         (clk),
    .rst_n       (rst2_n),
    .imem        (imem2),
    .stall       (stall2),
    .redirect    (redirect2),
    .redirect_pc (rpc2),
    .instruction (insn2),
    .PC          (pc2),
    .valid       (valid2)
  );

  int n_checks = 0;
  int n_errors = 0;

  // memory responder: 0 = always ack, 1 = random ack, 2 = ack after ack_delay waits
  int ack_mode = 0;
  int ack_delay = 4;
  int wait_cnt = 0;

  // reference model state
  logic [31:0] exp_pc = DUT_RESET;
  bit          discard_pending = 1'b0;
  bit          prev_pending = 1'b0;
  logic [31:0] prev_addr = 32'h0;

  // last pre-edge observation of the handshake
  logic        o_req;
  logic        o_ack;
  logic [31:0] o_addr;

  // One clock: respond to the request, check handshake rules, cross the
  // edge, then compare outputs against the model.
  task automatic tick();
    logic        p_req, p_ack, p_valid, p_stall, p_redir, p_rst;
    logic [31:0] p_addr, p_rpc, p_pc, p_insn, e_pc, e_insn;
    logic        e_valid;
    #1;
    p_req = imem.req;
    case (ack_mode)
      0:       imem.ack = p_req;
      1:       imem.ack = p_req && ($urandom_range(0, 99) < 60);
      default: imem.ack = p_req && (wait_cnt >= ack_delay);
    endcase
    imem.rdata = imem.addr ^ K;
    #1;
    p_req = imem.req;   p_addr = imem.addr;  p_ack = imem.ack;
    p_valid = valid;    p_stall = stall;     p_redir = redirect;
    p_rpc = redirect_pc; p_pc = pc_out;      p_insn = instruction;
    p_rst = rst_n;
    o_req = p_req; o_addr = p_addr; o_ack = p_ack;
    if (p_rst) begin
      if (prev_pending) begin
        n_checks++;
        if (p_req !== 1'b1 || p_addr !== prev_addr) begin
          n_errors++;
          $display("FAIL handshake_hold: req=%b addr=%h, required req=1 addr=%h", p_req, p_addr, prev_addr);
        end
      end
      if (p_req === 1'b1 && !discard_pending) begin
        n_checks++;
        if (p_addr !== exp_pc) begin
          n_errors++;
          $display("FAIL req_addr: addr=%h, required %h", p_addr, exp_pc);
        end
      end
      if (p_valid === 1'b1 && p_stall) begin
        n_checks++;
        if (p_req !== 1'b0) begin
          n_errors++;
          $display("FAIL stall_req: req=%b, required 0", p_req);
        end
      end
    end
    @(posedge clk);
    #1;
    if (!p_rst) begin
      e_valid = 1'b0; e_pc = 32'h0; e_insn = 32'h0;
      exp_pc = DUT_RESET; discard_pending = 1'b0; prev_pending = 1'b0; wait_cnt = 0;
    end else begin
      if (p_req && p_ack && !p_redir && !discard_pending) begin
        e_valid = 1'b1; e_pc = exp_pc; e_insn = exp_pc ^ K;
        exp_pc = exp_pc + 32'd4;
      end else if (p_valid && p_stall && !p_redir) begin
        e_valid = 1'b1; e_pc = p_pc; e_insn = p_insn;
      end else begin
        e_valid = 1'b0; e_pc = p_pc; e_insn = p_insn;
      end
      if (p_req && p_ack) discard_pending = 1'b0;
      if (p_redir) begin
        exp_pc = {p_rpc[31:2], 2'b00};
        if (p_req && !p_ack) discard_pending = 1'b1;
      end
      prev_pending = p_req && !p_ack;
      prev_addr = p_addr;
      if (p_req && !p_ack) wait_cnt++;
      else wait_cnt = 0;
    end
    n_checks++;
    if (valid !== e_valid) begin
      n_errors++;
      $display("FAIL model_valid: valid=%b, required %b", valid, e_valid);
    end
    n_checks++;
    if (pc_out !== e_pc) begin
      n_errors++;
      $display("FAIL model_pc: PC=%h, required %h", pc_out, e_pc);
    end
    n_checks++;
    if (instruction !== e_insn) begin
      n_errors++;
      $display("FAIL model_insn: instruction=%h, required %h", instruction, e_insn);
    end
  endtask

  task automatic reset_dut(input int n);
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0;
    repeat (n) tick();
    rst_n = 1'b1;
  endtask

  task automatic run_until(input logic [31:0] target, input int budget, output bit found);
    found = 1'b0;
    for (int c = 0; c < budget && !found; c++) begin
      tick();
      if (valid === 1'b1 && pc_out === target) found = 1'b1;
    end
  endtask

  task automatic test_reset();
    int first;
    ack_mode = 0;
    reset_dut(2);
    n_checks++;
    if (valid !== 1'b0 || pc_out !== 32'h0 || instruction !== 32'h0 || imem.req !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_state: valid=%b PC=%h insn=%h req=%b, required 0/0/0/0", valid, pc_out, instruction, imem.req);
    end
    first = -1;
    for (int c = 1; c <= 6 && first < 0; c++) begin
      tick();
      if (valid === 1'b1) first = c;
    end
    n_checks++;
    if (first != 2 || pc_out !== DUT_RESET) begin
      n_errors++;
      $display("FAIL first_valid: cycle=%0d PC=%h, required cycle 2 PC=%h", first, pc_out, DUT_RESET);
    end
    for (int i = 1; i <= 5; i++) begin
      tick();
      n_checks++;
      if (valid !== 1'b1 || pc_out !== 32'(4 * i) || instruction !== (32'(4 * i) ^ K)) begin
        n_errors++;
        $display("FAIL stream_pc: valid=%b PC=%h insn=%h, required 1 %h %h", valid, pc_out, instruction, 32'(4 * i), 32'(4 * i) ^ K);
      end
    end
  endtask

  task automatic test_stall();
    bit found;
    ack_mode = 0;
    reset_dut(1);
    run_until(32'h8, 20, found);
    n_checks++;
    if (!found) begin
      n_errors++;
      $display("FAIL stall_reach_pc8: found=0, required 1");
    end
    stall = 1'b1;
    repeat (3) begin
      tick();
      n_checks++;
      if (o_req !== 1'b0 || valid !== 1'b1 || pc_out !== 32'h8 || instruction !== (32'h8 ^ K)) begin
        n_errors++;
        $display("FAIL stall_freeze: req=%b valid=%b PC=%h insn=%h, required 0 1 00000008 %h", o_req, valid, pc_out, instruction, 32'h8 ^ K);
      end
    end
    stall = 1'b0;
    tick();
    n_checks++;
    if (valid !== 1'b0) begin
      n_errors++;
      $display("FAIL stall_bubble: valid=%b, required 0", valid);
    end
    tick();
    n_checks++;
    if (valid !== 1'b1 || pc_out !== 32'hC) begin
      n_errors++;
      $display("FAIL stall_resume: valid=%b PC=%h, required 1 0000000c", valid, pc_out);
    end
  endtask

  task automatic test_redirect_drain();
    logic [31:0] old_addr;
    bit got_ack, found;
    ack_mode = 2; ack_delay = 4;
    tick();
    old_addr = o_addr;
    n_checks++;
    if (o_req !== 1'b1 || o_ack !== 1'b0 || old_addr !== 32'h10) begin
      n_errors++;
      $display("FAIL drain_setup: req=%b ack=%b addr=%h, required 1 0 00000010", o_req, o_ack, old_addr);
    end
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    tick();
    redirect = 1'b0;
    got_ack = o_ack;
    for (int c = 0; c < 10 && !got_ack; c++) begin
      tick();
      got_ack = o_ack;
      n_checks++;
      if (o_addr !== old_addr || valid !== 1'b0) begin
        n_errors++;
        $display("FAIL drain_hold: addr=%h valid=%b, required %h 0", o_addr, valid, old_addr);
      end
    end
    n_checks++;
    if (!got_ack) begin
      n_errors++;
      $display("FAIL drain_timeout: ack seen=0, required 1");
    end
    tick();
    n_checks++;
    if (o_req !== 1'b1 || o_addr !== 32'h100) begin
      n_errors++;
      $display("FAIL drain_next_addr: req=%b addr=%h, required 1 00000100", o_req, o_addr);
    end
    run_until(32'h100, 10, found);
    n_checks++;
    if (!found || instruction !== (32'h100 ^ K)) begin
      n_errors++;
      $display("FAIL drain_target_out: found=%b insn=%h, required 1 %h", found, instruction, 32'h100 ^ K);
    end
    ack_mode = 0;
  endtask

  task automatic test_redirect_ack();
    logic [31:0] target;
    bit found;
    ack_mode = 0;
    reset_dut(1);
    run_until(32'hC, 20, found);
    redirect_pc = $urandom;
    target = redirect_pc & 32'hFFFF_FFFC;
    redirect = 1'b1;
    tick();
    redirect = 1'b0;
    n_checks++;
    if (!found || o_addr !== 32'h10 || o_ack !== 1'b1 || valid !== 1'b0) begin
      n_errors++;
      $display("FAIL redir_ack_drop: found=%b addr=%h ack=%b valid=%b, required 1 00000010 1 0", found, o_addr, o_ack, valid);
    end
    tick();
    n_checks++;
    if (o_addr !== target || valid !== 1'b1 || pc_out !== target || instruction !== (target ^ K)) begin
      n_errors++;
      $display("FAIL redir_ack_next: addr=%h valid=%b PC=%h insn=%h, required %h 1 %h %h", o_addr, valid, pc_out, instruction, target, target, target ^ K);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] seen [$];
    logic [31:0] want [3];
    want[0] = 32'hFFFF_FFF8; want[1] = 32'hFFFF_FFFC; want[2] = 32'h0000_0000;
    ack_mode = 0;
    rst2_n = 1'b0;
    tick(); tick();
    rst2_n = 1'b1;
    for (int c = 0; c < 8 && seen.size() < 3; c++) begin
      tick();
      if (valid2 === 1'b1) begin
        seen.push_back(pc2);
        n_checks++;
        if (insn2 !== (pc2 ^ K)) begin
          n_errors++;
          $display("FAIL wrap_insn: insn=%h, required %h", insn2, pc2 ^ K);
        end
      end
    end
    n_checks++;
    if (seen.size() != 3) begin
      n_errors++;
      $display("FAIL wrap_count: outputs=%0d, required 3", seen.size());
    end
    for (int i = 0; i < seen.size() && i < 3; i++) begin
      n_checks++;
      if (seen[i] !== want[i]) begin
        n_errors++;
        $display("FAIL wrap_pc: PC=%h, required %h", seen[i], want[i]);
      end
    end
  endtask

  task automatic test_reset_midflight();
    bit found;
    // reset while a request waits for its ack
    ack_mode = 0;
    reset_dut(1);
    run_until(32'h4, 20, found);
    ack_mode = 2; ack_delay = 6; wait_cnt = 0;
    tick(); tick();
    n_checks++;
    if (!found || o_req !== 1'b1 || o_ack !== 1'b0) begin
      n_errors++;
      $display("FAIL mid_setup: found=%b req=%b ack=%b, required 1 1 0", found, o_req, o_ack);
    end
    rst_n = 1'b0;
    tick();
    n_checks++;
    if (valid !== 1'b0 || pc_out !== 32'h0 || instruction !== 32'h0 || imem.req !== 1'b0) begin
      n_errors++;
      $display("FAIL mid_reset_req: valid=%b PC=%h insn=%h req=%b, required 0/0/0/0", valid, pc_out, instruction, imem.req);
    end
    rst_n = 1'b1;
    ack_mode = 0;
    tick(); tick();
    n_checks++;
    if (o_req !== 1'b1 || o_addr !== DUT_RESET) begin
      n_errors++;
      $display("FAIL mid_restart: req=%b addr=%h, required 1 %h", o_req, o_addr, DUT_RESET);
    end
    // reset while holding a stalled instruction
    run_until(32'h8, 20, found);
    stall = 1'b1;
    tick(); tick();
    rst_n = 1'b0;
    tick();
    n_checks++;
    if (!found || valid !== 1'b0 || pc_out !== 32'h0 || instruction !== 32'h0 || imem.req !== 1'b0) begin
      n_errors++;
      $display("FAIL hold_reset: found=%b valid=%b PC=%h insn=%h req=%b, required 1 0 0 0 0", found, valid, pc_out, instruction, imem.req);
    end
    stall = 1'b0;
    rst_n = 1'b1;
    tick(); tick();
    n_checks++;
    if (o_req !== 1'b1 || o_addr !== DUT_RESET) begin
      n_errors++;
      $display("FAIL hold_restart: req=%b addr=%h, required 1 %h", o_req, o_addr, DUT_RESET);
    end
  endtask

  task automatic test_random();
    ack_mode = 1;
    reset_dut(1);
    for (int c = 0; c < 3000; c++) begin
      stall       = ($urandom_range(0, 99) < 30);
      redirect    = ($urandom_range(0, 99) < 6);
      redirect_pc = $urandom;
      rst_n       = !($urandom_range(0, 199) == 0);
      tick();
    end
    rst_n = 1'b1; stall = 1'b0; redirect = 1'b0;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; rst2_n = 1'b0;
    stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    imem.ack = 1'b0; imem.rdata = 32'h0;
    test_reset();
    test_stall();
    test_redirect_drain();
    test_redirect_ack();
    test_wrap();
    test_reset_midflight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

endmodule
